// File: rtl/jpeg_quant_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jpeg_quant_sched: issues one 8x8 block of DCT coefficients to an     |
// | external pipelined divider and returns signed, in-order results.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jpeg_quant_sched #(
  parameter int COEF_W    = 12,
  parameter int QT_W      = 8,
  parameter int DIV_W     = 13,
  parameter int Q_W       = 8,
  parameter int DIV_LAT   = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              qt_wr_en,
  input  logic [5:0]        qt_wr_addr,
  input  logic [QT_W-1:0]   qt_wr_data,
  output logic              qt_wr_ready,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [COEF_W-1:0] s_data,
  input  logic              s_sof,
  output logic [DIV_W-1:0]  div_dividend,
  output logic [DIV_W-1:0]  div_divisor,
  output logic              div_din_valid,
  input  logic [Q_W-1:0]    div_quotient,
  input  logic              div_dout_valid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [Q_W:0]      m_data,
  output logic [5:0]        m_idx,
  output logic              m_last,
  output logic              busy,
  output logic              err_sof,
  output logic              err_sync
);

  localparam int TAG_W = 9;
  localparam int FW    = Q_W + 1 + 6 + 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int CR_W  = $clog2(OUT_DEPTH + DIV_LAT + 1) + 1;
  localparam int PTR_W = $clog2(OUT_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state, w_state_nxt;
  logic [5:0]        r_idx;
  logic [QT_W-1:0]   r_qt [64];
  logic [TAG_W-1:0]  r_tag [DIV_LAT];
  logic [CR_W-1:0]   r_inflight;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [FW-1:0]     r_mem [OUT_DEPTH];
  logic              r_live, r_err_sof, r_err_sync;

  logic              w_take_ok, w_accept, w_push, w_pop, w_full;
  logic [CR_W-1:0]   w_credit;
  logic [COEF_W:0]   w_ext, w_mag;
  logic [TAG_W-1:0]  w_tag_in, w_tag_out;
  logic              w_tag_v, w_tag_sign, w_tag_last;
  logic [5:0]        w_tag_idx;
  logic [Q_W:0]      w_qext, w_res;

  // FSM: state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && r_idx == 6'd63) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_inflight == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy        = (r_state != S_IDLE);
    qt_wr_ready = (r_state == S_IDLE) || (r_state == S_DRAIN);
    w_take_ok   = (r_state != S_DRAIN);
  end

  // Credit covers both in-flight divisions and queued results, so the
  // non-stallable divider can never overrun the FIFO.
  assign w_credit      = CR_W'(r_count) + r_inflight;
  assign s_ready       = r_live && w_take_ok && (w_credit < CR_W'(OUT_DEPTH));
  assign w_accept      = s_valid && s_ready;
  assign div_din_valid = w_accept;

  assign w_ext        = {s_data[COEF_W-1], s_data};
  assign w_mag        = s_data[COEF_W-1] ? -w_ext : w_ext;
  assign div_dividend = DIV_W'(w_mag);
  assign div_divisor  = DIV_W'(r_qt[r_idx]);

  assign w_tag_in   = {w_accept, s_data[COEF_W-1], r_idx, (r_idx == 6'd63)};
  assign w_tag_out  = r_tag[DIV_LAT-1];
  assign w_tag_v    = w_tag_out[8];
  assign w_tag_sign = w_tag_out[7];
  assign w_tag_idx  = w_tag_out[6:1];
  assign w_tag_last = w_tag_out[0];

  assign w_qext = {1'b0, div_quotient};
  assign w_res  = w_tag_sign ? -w_qext : w_qext;

  assign m_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_W'(OUT_DEPTH));
  assign w_pop   = m_valid && m_ready;
  assign w_push  = div_dout_valid && (!w_full || w_pop);
  assign {m_data, m_idx, m_last} = r_mem[r_rd_ptr];

  assign err_sof  = r_err_sof;
  assign err_sync = r_err_sync;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 64; i++) r_qt[i] <= QT_W'(1);
    end else if (qt_wr_en && qt_wr_ready) begin
      r_qt[qt_wr_addr] <= (qt_wr_data == '0) ? QT_W'(1) : qt_wr_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DIV_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < DIV_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_live     <= 1'b0;
      r_idx      <= '0;
      r_inflight <= '0;
      r_err_sof  <= 1'b0;
      r_err_sync <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) r_idx <= r_idx + 6'd1;
      if (w_accept && !w_tag_v)      r_inflight <= r_inflight + CR_W'(1);
      else if (!w_accept && w_tag_v) r_inflight <= r_inflight - CR_W'(1);
      if (w_accept && (s_sof != (r_idx == 6'd0))) r_err_sof <= 1'b1;
      if (div_dout_valid != w_tag_v)              r_err_sync <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage only; occupancy is governed by the pointers and count above.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_res, w_tag_idx, w_tag_last};
  end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_quant_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jpeg_quant_sched: scoreboard bench with a pipelined divider model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_jpeg_quant_sched;

  localparam int DIV_LAT   = 8;
  localparam int OUT_DEPTH = 8;

  logic        clk, nrst;
  logic        qt_wr_en, qt_wr_ready;
  logic [5:0]  qt_wr_addr;
  logic [7:0]  qt_wr_data;
  logic        s_valid, s_ready, s_sof;
  logic [11:0] s_data;
  logic [12:0] div_dividend, div_divisor;
  logic        div_din_valid, div_dout_valid;
  logic [7:0]  div_quotient;
  logic        m_valid, m_ready, m_last;
  logic [8:0]  m_data;
  logic [5:0]  m_idx;
  logic        busy, err_sof, err_sync;

  int total = 0;
  int bad   = 0;

  logic [15:0] sb[$];
  int          bidx;
  logic [7:0]  tq [64];

  jpeg_quant_sched #(
    .COEF_W(12), .QT_W(8), .DIV_W(13), .Q_W(8), .DIV_LAT(DIV_LAT), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .nrst(nrst),
    .qt_wr_en(qt_wr_en), .qt_wr_addr(qt_wr_addr), .qt_wr_data(qt_wr_data),
    .qt_wr_ready(qt_wr_ready),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_din_valid(div_din_valid),
    .div_quotient(div_quotient), .div_dout_valid(div_dout_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
    .busy(busy), .err_sof(err_sof), .err_sync(err_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // Divider quotient: fractional long division, dividend scaled by 2^7.
  function automatic logic [7:0] qmodel(input logic [12:0] a, input logic [12:0] b);
    logic [31:0] t;
    t = ({19'd0, a} << 7) / {19'd0, b};
    return t[7:0];
  endfunction

  function automatic logic [11:0] coef(input int mode, input int i);
    int v;
    case (mode)
      0:       v = 100;
      2:       v = (i == 0) ? -100 : (i == 1) ? -2048 : (i == 2) ? 0 : ((i * 173) % 4001) - 2000;
      default: v = ((i * 173) % 4001) - 2000;
    endcase
    return 12'(v);
  endfunction

  logic [7:0] dq [DIV_LAT];
  logic       dv [DIV_LAT];
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DIV_LAT; i++) begin
        dv[i] <= 1'b0;
        dq[i] <= 8'd0;
      end
    end else begin
      dv[0] <= div_din_valid;
      dq[0] <= div_din_valid ? qmodel(div_dividend, div_divisor) : 8'd0;
      for (int i = 1; i < DIV_LAT; i++) begin
        dv[i] <= dv[i-1];
        dq[i] <= dq[i-1];
      end
    end
  end
  assign div_dout_valid = dv[DIV_LAT-1];
  assign div_quotient   = dq[DIV_LAT-1];

  int         i_d, i_mag, i_dvs;
  logic [7:0] i_q;
  logic [8:0] i_e;
  always @(negedge clk) begin
    if (nrst) begin
      if (s_valid && s_ready) begin
        i_d   = $signed(s_data);
        i_mag = (i_d < 0) ? -i_d : i_d;
        i_dvs = int'(tq[bidx]);
        total++;
        if (div_din_valid !== 1'b1 || div_dividend !== 13'(i_mag) || div_divisor !== 13'(i_dvs)) begin
          bad++;
          $display("FAIL issue idx=%0d got v=%b dd=%0d dv=%0d want v=1 dd=%0d dv=%0d",
                   bidx, div_din_valid, div_dividend, div_divisor, i_mag, i_dvs);
        end
        total++;
        if (sb.size() >= OUT_DEPTH) begin
          bad++;
          $display("FAIL credit got outstanding=%0d want <%0d", sb.size(), OUT_DEPTH);
        end
        i_q = qmodel(13'(i_mag), 13'(i_dvs));
        i_e = (i_d < 0) ? (9'd0 - {1'b0, i_q}) : {1'b0, i_q};
        sb.push_back({i_e, 6'(bidx), (bidx == 63)});
        bidx = (bidx + 1) % 64;
      end else begin
        total++;
        if (div_din_valid !== 1'b0) begin
          bad++;
          $display("FAIL din_idle got %b want 0", div_din_valid);
        end
      end
    end
  end

  logic [15:0] p_exp;
  always @(negedge clk) begin
    if (nrst && m_valid && m_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got data=%0d idx=%0d last=%b want none", m_data, m_idx, m_last);
      end else begin
        p_exp = sb.pop_front();
        if ({m_data, m_idx, m_last} !== p_exp) begin
          bad++;
          $display("FAIL result got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                   m_data, m_idx, m_last, p_exp[15:7], p_exp[6:1], p_exp[0]);
        end
      end
    end
  end

  task automatic beat(input logic [11:0] d, input logic sof);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!s_ready) begin
      bad++;
      $display("FAIL beat_timeout got s_ready=0 want 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic qt_write(input int a, input int d, input logic exp_rdy);
    @(posedge clk);
    #1;
    qt_wr_en   = 1'b1;
    qt_wr_addr = 6'(a);
    qt_wr_data = 8'(d);
    @(negedge clk);
    total++;
    if (qt_wr_ready !== exp_rdy) begin
      bad++;
      $display("FAIL qt_wr_ready got %b want %b", qt_wr_ready, exp_rdy);
    end
    @(posedge clk);
    #1;
    qt_wr_en = 1'b0;
    if (exp_rdy) tq[a] = (d == 0) ? 8'd1 : 8'(d);
  endtask

  task automatic send_block(input int mode, input int flip);
    for (int i = 0; i < 64; i++) beat(coef(mode, i), (i == 0) ^ (i == flip));
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drain got pending=%0d busy=%b want 0 0", sb.size(), busy);
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL extra_out got m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    s_valid = 1'b1;
    s_data = 12'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || div_din_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got m_valid=%b busy=%b din=%b want 0 0 0", m_valid, busy, div_din_valid);
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || qt_wr_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got s_ready=%b qt_rdy=%b busy=%b m_valid=%b want 1 1 0 0",
               s_ready, qt_wr_ready, busy, m_valid);
    end
    total++;
    if (err_sof !== 1'b0 || err_sync !== 1'b0) begin
      bad++;
      $display("FAIL reset_err got sof=%b sync=%b want 0 0", err_sof, err_sync);
    end
    @(posedge clk);
    #1;
    send_block(1, -1);
    wait_drain();
  endtask

  task automatic test_block100;
    int n;
    for (int a = 0; a < 64; a++) qt_write(a, 100, 1'b1);
    send_block(0, -1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 30);
    total++;
    if (n < DIV_LAT || n > DIV_LAT + 2) begin
      bad++;
      $display("FAIL busy_fall got %0d cycles want %0d..%0d", n, DIV_LAT, DIV_LAT + 2);
    end
    wait_drain();
  endtask

  task automatic test_signs;
    qt_write(0, 100, 1'b1);
    qt_write(1, 16, 1'b1);
    qt_write(2, 0, 1'b1);
    send_block(2, -1);
    wait_drain();
  endtask

  task automatic test_backpressure;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < OUT_DEPTH; i++) beat(coef(1, i), i == 0);
    s_valid = 1'b1;
    s_data  = coef(1, OUT_DEPTH);
    s_sof   = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (s_ready !== 1'b0 || sb.size() != OUT_DEPTH) begin
      bad++;
      $display("FAIL stall got s_ready=%b accepted=%0d want 0 %0d", s_ready, sb.size(), OUT_DEPTH);
    end
    total++;
    if (m_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_valid got m_valid=%b want 1", m_valid);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    for (int i = OUT_DEPTH; i < 64; i++) beat(coef(1, i), 1'b0);
    wait_drain();
  endtask

  task automatic test_qt_run_drain;
    @(posedge clk);
    #1;
    total++;
    if (err_sof !== 1'b0) begin
      bad++;
      $display("FAIL sof_clean got %b want 0", err_sof);
    end
    for (int i = 0; i < 64; i++) begin
      beat(coef(1, i), 1'b0);
      if (i == 0) begin
        total++;
        if (err_sof !== 1'b1) begin
          bad++;
          $display("FAIL sof_missing got %b want 1", err_sof);
        end
      end
      if (i == 6) qt_write(10, 50, 1'b0);
    end
    qt_write(10, 50, 1'b1);
    wait_drain();
  endtask

  task automatic test_nrst_mid;
    @(posedge clk);
    #1;
    for (int i = 0; i <= 30; i++) beat(coef(1, i), i == 0);
    s_valid = 1'b1;
    s_data  = coef(1, 31);
    nrst    = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || div_din_valid !== 1'b0 || err_sof !== 1'b0) begin
      bad++;
      $display("FAIL nrst_async got m_valid=%b busy=%b din=%b err_sof=%b want 0 0 0 0",
               m_valid, busy, div_din_valid, err_sof);
    end
    sb.delete();
    bidx = 0;
    for (int a = 0; a < 64; a++) tq[a] = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    nrst    = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || qt_wr_ready !== 1'b1 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL nrst_release got s_ready=%b qt_rdy=%b m_valid=%b want 1 1 0", s_ready, qt_wr_ready, m_valid);
    end
    @(posedge clk);
    #1;
    send_block(1, 5);
    total++;
    if (err_sof !== 1'b1) begin
      bad++;
      $display("FAIL sof_extra got %b want 1", err_sof);
    end
    wait_drain();
    total++;
    if (err_sync !== 1'b0) begin
      bad++;
      $display("FAIL err_sync got %b want 0", err_sync);
    end
  endtask

  initial begin
    nrst       = 1'b0;
    qt_wr_en   = 1'b0;
    qt_wr_addr = 6'd0;
    qt_wr_data = 8'd0;
    s_valid    = 1'b0;
    s_data     = 12'd0;
    s_sof      = 1'b0;
    m_ready    = 1'b1;
    bidx       = 0;
    for (int a = 0; a < 64; a++) tq[a] = 8'd1;
    test_reset();
    test_block100();
    test_signs();
    test_backpressure();
    test_qt_run_drain();
    test_nrst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
